// File: rtl/demux.sv
// Registered 1-to-4 demultiplexer with a single cycle of latency and a selectable out-of-range policy.
// Optional feature: define DEMUX_ERR_EN to add the registered out-of-range flag `err`.
module demux #(
    parameter bit ZERO_ON_OOR = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] y,
    input  logic [2:0] S,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d
`ifdef DEMUX_ERR_EN
    ,
    output logic       err
`endif
);

    logic [3:0] q_p0;
    logic [3:0] q_next;
`ifdef DEMUX_ERR_EN
    logic       err_p0;
    logic       err_next;
`endif

    always_comb begin
        q_next = 4'b0000;
`ifdef DEMUX_ERR_EN
        err_next = 1'b0;
`endif
        case (S)
            3'd0:    q_next[0] = y[0];
            3'd1:    q_next[1] = y[1];
            3'd2:    q_next[2] = y[2];
            3'd3:    q_next[3] = y[3];
            // Codes 4..7 and any unknown select fall here.
            default: begin
                q_next = ZERO_ON_OOR ? 4'b0000 : q_p0;
`ifdef DEMUX_ERR_EN
                err_next = 1'b1;
`endif
            end
        endcase
    end

    // Stage p0: output register, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_p0 <= 4'b0000;
        end else begin
            q_p0 <= q_next;
        end
    end

`ifdef DEMUX_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_p0 <= 1'b0;
        end else begin
            err_p0 <= err_next;
        end
    end

    assign err = err_p0;
`endif

    assign a = q_p0[0];
    assign b = q_p0[1];
    assign c = q_p0[2];
    assign d = q_p0[3];

endmodule

// File: tb/tb_demux.sv
// Scoreboard bench for demux: one instance per out-of-range policy, both driven from the same inputs.
module tb_demux;

    logic       clk;
    logic       rst_n;
    logic [3:0] y;
    logic [2:0] S;
    logic       az, bz, cz, dz;
    logic       ah, bh, ch, dh;
`ifdef DEMUX_ERR_EN
    logic       errz, errh;
`endif

    demux #(.ZERO_ON_OOR(1'b1)) dut_zero (
        .clk   (clk),
        .rst_n (rst_n),
        .y     (y),
        .S     (S),
        .a     (az),
        .b     (bz),
        .c     (cz),
        .d     (dz)
`ifdef DEMUX_ERR_EN
        ,
        .err   (errz)
`endif
    );

    demux #(.ZERO_ON_OOR(1'b0)) dut_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .y     (y),
        .S     (S),
        .a     (ah),
        .b     (bh),
        .c     (ch),
        .d     (dh)
`ifdef DEMUX_ERR_EN
        ,
        .err   (errh)
`endif
    );

    typedef struct {
        logic [3:0] qz;
        logic [3:0] qh;
        logic       e;
        string      tag;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] mz, mh;
    int         n_pass = 0;
    int         n_checks = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%b exp=%b", tag, got, exp);
    endtask

    // Reference next-state: selected bit of y, or clear/hold for codes 4..7.
    function automatic logic [3:0] ref_next(logic [3:0] yv, logic [2:0] sv,
                                            logic [3:0] prev, bit zero);
        if (sv[2]) return zero ? 4'b0000 : prev;
        return yv & (4'b0001 << sv[1:0]);
    endfunction

    task automatic push(input string tag);
        exp_t e;
        if (rst_n) begin
            mz = ref_next(y, S, mz, 1'b1);
            mh = ref_next(y, S, mh, 1'b0);
            e.e = S[2];
        end else begin
            mz = 4'b0000;
            mh = 4'b0000;
            e.e = 1'b0;
        end
        e.qz  = mz;
        e.qh  = mh;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [3:0] yv, input logic [2:0] sv, input string tag);
        @(negedge clk);
        y = yv;
        S = sv;
        push(tag);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, "_zero"}, {4'b0, dz, cz, bz, az}, {4'b0, e.qz});
            check({e.tag, "_hold"}, {4'b0, dh, ch, bh, ah}, {4'b0, e.qh});
`ifdef DEMUX_ERR_EN
            check({e.tag, "_err"}, {6'b0, errh, errz}, {6'b0, e.e, e.e});
`endif
        end
    end

    initial begin
        mz    = 4'b0000;
        mh    = 4'b0000;
        rst_n = 1'b0;
        y     = 4'b1011;
        S     = 3'd2;
        #1;
        check("reset_init", {dh, ch, bh, ah, dz, cz, bz, az}, 8'h00);

        // Held in reset while clocking with active-looking inputs
        for (int i = 0; i < 3; i++) drive(4'b1011, 3'd2, "in_reset");

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) drive(4'b1011, 3'(i), "step_sel");
        drive(4'b0000, 3'd4, "zero_y_s4");
        for (int i = 3; i >= 0; i--) drive(4'b0000, 3'(i), "zero_y");

        // Hold policy: b loaded then kept across out-of-range selects
        drive(4'b1111, 3'd1, "load_b");
        for (int i = 0; i < 3; i++) drive(4'b1111, 3'd6, "oor_hold");
        drive(4'b1111, 3'd0, "after_oor");
        drive(4'b1000, 3'd7, "oor7");
        drive(4'b1000, 3'd3, "load_d");
        drive(4'b1000, 3'd5, "oor5");

        for (int i = 0; i < 24; i++)
            drive(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), "rand");

        drive(4'b0001, 3'd0, "load_a");
        // Asynchronous reset pulse between edges, released before the next edge
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clr", {dh, ch, bh, ah, dz, cz, bz, az}, 8'h00);
`ifdef DEMUX_ERR_EN
        check("async_clr_err", {6'b0, errh, errz}, 8'h00);
`endif
        mz = 4'b0000;
        mh = 4'b0000;
        #1;
        rst_n = 1'b1;
        y = 4'b0001;
        S = 3'd0;
        push("reload_a");

        drive(4'b1111, 3'd6, "post_oor");
        drive(4'b0100, 3'd2, "load_c");

        repeat (3) @(posedge clk);
        #2;
        check("drain", 8'(sb.size()), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/demux.md
DEMUX -- requirements
Module: demux

Interface
REQ-001 Parameter ZERO_ON_OOR, default 1: out-of-range select behaviour; 1 = clear all outputs, 0 = hold all outputs.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 y  input  4  data word; bit y[k] is the candidate value for channel k.
REQ-005 S  input  3  channel select; 0..3 valid, 4..7 out-of-range.
REQ-006 a  output  1  channel 0 output, registered.
REQ-007 b  output  1  channel 1 output, registered.
REQ-008 c  output  1  channel 2 output, registered.
REQ-009 d  output  1  channel 3 output, registered.
REQ-010 err  output  1  out-of-range select flag, registered; present only when DEMUX_ERR_EN is defined.

Function
REQ-011 Each rising clk edge with rst_n high SHALL sample y and S and update the outputs; latency is exactly 1 clock cycle.
REQ-012 S = 0 SHALL load a <= y[0]; S = 1 loads b <= y[1]; S = 2 loads c <= y[2]; S = 3 loads d <= y[3].
REQ-013 On a valid select, all non-selected outputs SHALL be loaded with 0, so at most one output is 1.
REQ-014 S in 4..7 with ZERO_ON_OOR = 1 SHALL load 0 into a, b, c and d.
REQ-015 S in 4..7 with ZERO_ON_OOR = 0 SHALL leave a, b, c and d unchanged.
REQ-016 Only S[2:0] is decoded; no other input bits exist.
REQ-017 y and S changing on the same edge SHALL behave as a single sample of both values; no ordering dependency.
REQ-018 Outputs SHALL depend only on the sampled values; there are no combinational paths from inputs to outputs.
REQ-019 Any X/Z on S SHALL be treated as out-of-range; RTL uses a full case with default.

Reset
REQ-020 rst_n low SHALL immediately force a, b, c and d (and err) to 0, independent of clk.
REQ-021 Deassertion of rst_n SHALL take effect at the next rising clk edge; the first post-reset edge samples normally.
REQ-022 Reset asserted mid-operation SHALL discard any sampled value; no state survives reset.

Configuration
REQ-023 With DEMUX_ERR_EN defined, err SHALL be loaded with 1 when the sampled S is 4..7 and 0 otherwise, using the same 1-cycle latency.
REQ-024 With DEMUX_ERR_EN defined, err SHALL reset to 0.
REQ-025 Without DEMUX_ERR_EN, the err port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-026 rst_n = 0 with y = 4'b1011 and S = 2 while clocking -> a = b = c = d = 0 throughout.
REQ-027 rst_n = 1, y = 4'b1011, S stepped 0,1,2,3 one per cycle -> one cycle later (a,b,c,d) = 1000, 0100, 0000, 0001.
REQ-028 y = 4'b0000, S stepped 4,3,2,1,0 -> all outputs 0 every cycle; with DEMUX_ERR_EN, err = 1 only for the S = 4 cycle.
REQ-029 ZERO_ON_OOR = 0: y = 4'b1111, S = 1 then S = 6 for 3 cycles -> b stays 1 and the others stay 0 through the S = 6 cycles; then S = 0 -> a = 1, b = 0.
REQ-030 Registered a = 1, then rst_n pulsed low between edges -> a falls to 0 immediately without a clock edge; the next edge after release reloads a from y[0].
